// File: rtl/key_debounce.sv
// Eight-key front end: 2-flop sync, shared tick prescaler, per-key debounce,
// press/release pulses and single-key index decode.
module key_debounce #(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_raw,
  output logic [7:0] key,
  output logic [7:0] key_press,
  output logic [7:0] key_release,
  output logic       key_valid,
  output logic [2:0] key_idx
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [4:0] C_LAST = 5'(STABLE_TICKS - 1);

  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  logic [PW-1:0] r_pre;
  logic [4:0]    r_cnt [8];
  logic [7:0]    r_key;
  logic [7:0]    r_press;
  logic [7:0]    r_rel;
  logic          r_valid;
  logic [2:0]    r_idx;

  logic          w_tick;
  logic [4:0]    w_cnt_nxt [8];
  logic [7:0]    w_key_nxt;
  logic [7:0]    w_press_nxt;
  logic [7:0]    w_rel_nxt;
  logic [3:0]    w_nlow;
  logic [2:0]    w_idx;
  logic          w_one;

  assign w_tick = (r_pre == P_LAST);

  // A key returning to its debounced level restarts qualification
  always_comb begin
    w_key_nxt   = r_key;
    w_press_nxt = '0;
    w_rel_nxt   = '0;
    for (int i = 0; i < 8; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (r_sync2[i] == r_key[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (w_tick && (r_cnt[i] == C_LAST)) begin
        w_cnt_nxt[i]   = '0;
        w_key_nxt[i]   = r_sync2[i];
        w_press_nxt[i] = ~r_sync2[i];
        w_rel_nxt[i]   = r_sync2[i];
      end else if (w_tick) begin
        w_cnt_nxt[i] = r_cnt[i] + 5'd1;
      end
    end
  end

  always_comb begin
    w_nlow = '0;
    w_idx  = '0;
    for (int i = 0; i < 8; i++) begin
      if (!r_key[i]) begin
        w_nlow = w_nlow + 4'd1;
        w_idx  = 3'(i);
      end
    end
    w_one = (w_nlow == 4'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_pre   <= '0;
      r_key   <= '1;
      r_press <= '0;
      r_rel   <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
      r_pre   <= w_tick ? '0 : r_pre + PW'(1);
      r_key   <= w_key_nxt;
      r_press <= w_press_nxt;
      r_rel   <= w_rel_nxt;
      r_valid <= w_one;
      r_idx   <= w_one ? w_idx : 3'd0;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign key         = r_key;
  assign key_press   = r_press;
  assign key_release = r_rel;
  assign key_valid   = r_valid;
  assign key_idx     = r_idx;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random key activity,
// checked every cycle against a tick-counting behavioural model.
module tb_key_debounce;

  localparam int TD = 4;
  localparam int ST = 3;

  logic       clk;
  logic       reset;
  logic [7:0] key_raw;
  logic [7:0] key;
  logic [7:0] key_press;
  logic [7:0] key_release;
  logic       key_valid;
  logic [2:0] key_idx;

  int vecs;
  int errs;

  key_debounce #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk(clk),
    .reset(reset),
    .key_raw(key_raw),
    .key(key),
    .key_press(key_press),
    .key_release(key_release),
    .key_valid(key_valid),
    .key_idx(key_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: delay line of raw samples, cycle phase, ticks seen while differing
  logic [7:0] m_s1 = 8'hFF;
  logic [7:0] m_s2 = 8'hFF;
  int         m_phase = 0;
  int         m_run [8] = '{default: 0};
  logic [7:0] m_key = 8'hFF;
  logic [7:0] m_press = 8'h00;
  logic [7:0] m_rel = 8'h00;
  logic       m_valid = 1'b0;
  logic [2:0] m_idx = 3'd0;

  always @(posedge clk) begin
    bit         tick;
    logic [7:0] ks;
    logic [7:0] old_key;
    if (reset) begin
      m_s1 = 8'hFF; m_s2 = 8'hFF; m_phase = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_key = 8'hFF; m_press = 0; m_rel = 0; m_valid = 0; m_idx = 0;
    end else begin
      tick    = ((m_phase % TD) == TD - 1);
      m_phase = (m_phase + 1) % TD;
      ks      = m_s2;
      old_key = m_key;
      m_valid = ($countones(~old_key) == 1);
      m_idx   = 0;
      if (m_valid)
        for (int i = 0; i < 8; i++) if (!old_key[i]) m_idx = 3'(i);
      m_press = 0;
      m_rel   = 0;
      for (int i = 0; i < 8; i++) begin
        if (ks[i] == old_key[i]) m_run[i] = 0;
        else if (tick) begin
          m_run[i]++;
          if (m_run[i] == ST) begin
            m_run[i]   = 0;
            m_key[i]   = ks[i];
            m_press[i] = !ks[i];
            m_rel[i]   = ks[i];
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = key_raw;
    end
  end

  always @(negedge clk) begin
    chk("m_key", key, m_key);
    chk("m_press", key_press, m_press);
    chk("m_release", key_release, m_rel);
    chk("m_valid", key_valid, m_valid);
    chk("m_idx", key_idx, m_idx);
  end

  task automatic wait_key(input logic [7:0] tgt, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (key !== tgt && n < 40);
  endtask

  initial begin
    int n;
    int pulses;
    vecs = 0;
    errs = 0;
    reset = 1'b1;
    key_raw = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_key", key, 8'hFF);
    chk("rst_press", key_press, 8'h00);
    chk("rst_rel", key_release, 8'h00);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_idx", key_idx, 3'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_key", key, 8'hFF);
    chk("post_rst_press", key_press, 8'h00);
    chk("post_rst_valid", key_valid, 1'b0);
    key_raw = 8'hFF;
    repeat (20) @(negedge clk);

    key_raw = 8'hFB;
    wait_key(8'hFB, n);
    chk("press_lat_ok", (n >= 11 && n <= 14), 1);
    chk("press_val", key_press, 8'h04);
    @(negedge clk);
    chk("press_one_clk", key_press, 8'h00);
    chk("press_valid", key_valid, 1'b1);
    chk("press_idx", key_idx, 3'd2);
    repeat (5) @(negedge clk);

    key_raw = 8'hFF;
    wait_key(8'hFF, n);
    chk("rel_lat_ok", (n >= 11 && n <= 14), 1);
    chk("rel_val", key_release, 8'h04);
    @(negedge clk);
    chk("rel_one_clk", key_release, 8'h00);
    chk("rel_valid", key_valid, 1'b0);
    chk("rel_idx", key_idx, 3'd0);
    repeat (5) @(negedge clk);

    for (int c = 0; c < 60; c++) begin
      if (c % 5 == 0) key_raw[0] = ~key_raw[0];
      @(negedge clk);
      chk("bounce_key", key, 8'hFF);
      chk("bounce_ev", {key_press, key_release}, 16'h0000);
    end
    key_raw = 8'hFF;
    repeat (20) @(negedge clk);

    key_raw = 8'h7E;
    wait_key(8'h7E, n);
    chk("multi_lat_ok", (n >= 11 && n <= 14), 1);
    chk("multi_press", key_press, 8'h81);
    @(negedge clk);
    chk("multi_valid", key_valid, 1'b0);
    key_raw = 8'hFF;
    repeat (25) @(negedge clk);

    key_raw = 8'hFD;
    n = 0;
    while (m_run[1] != 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reached", (m_run[1] == 2), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_key", key, 8'hFF);
    chk("midrst_press", key_press, 8'h00);
    wait_key(8'hFD, n);
    chk("requal_lat_ok", (n >= 11 && n <= 14), 1);
    chk("requal_press", key_press, 8'h02);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (key_press != 0) pulses++;
    end
    chk("requal_single", pulses, 0);

    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      reset = 1'b0;
      if (r < 3) key_raw = 8'($urandom);
      else if (r < 8) key_raw[$urandom_range(0, 7)] ^= 1'b1;
      else if (r == 99 && $urandom_range(0, 9) == 0) reset = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
